// File: rtl/status_reg_pkg.sv
// rtl/status_reg_pkg.sv - shared flag indices, flag-op encodings and update-mask bit order
package status_reg_pkg;

    // Bit positions of the flags within the P byte
    localparam int P_N = 7;
    localparam int P_V = 6;
    localparam int P_B = 4;
    localparam int P_D = 3;
    localparam int P_I = 2;
    localparam int P_Z = 1;
    localparam int P_C = 0;

    // Bit positions inside upd_mask, which is ordered {N,V,Z,C}
    localparam int UPD_N = 3;
    localparam int UPD_V = 2;
    localparam int UPD_Z = 1;
    localparam int UPD_C = 0;

    // Explicit flag instructions; the control decoder uses the same codes
    typedef enum logic [2:0] {
        FOP_CLC = 3'd0,
        FOP_SEC = 3'd1,
        FOP_CLI = 3'd2,
        FOP_SEI = 3'd3,
        FOP_CLV = 3'd4,
        FOP_CLD = 3'd5,
        FOP_SED = 3'd6,
        FOP_NOP = 3'd7
    } flag_op_e;

endpackage

// File: rtl/status_reg.sv
// rtl/status_reg.sv - 6502 processor status register with delayed interrupt mask
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   alu_n/v/z/c                   ALU flag results
//   upd_en, upd_mask[3:0]         apply ALU flags, per-flag select {N,V,Z,C}
//   flag_en, flag_op[2:0]         explicit set/clear flag instruction
//   load_p, rti, db_in[7:0]       load P from stack byte (PLP, or RTI when rti=1)
//   int_entry                     interrupt/BRK entry, forces I=1
//   push_b                        B bit inserted into p_push
//   instr_done                    instruction boundary strobe
//   p_push[7:0]                   byte pushed to the stack
//   c_out, d_out                  stored C and D
//   irq_mask                      I as seen by interrupt arbitration
module status_reg
    import status_reg_pkg::*;
#(
    parameter logic [7:0] P_RST = 8'h24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alu_n,
    input  logic       alu_v,
    input  logic       alu_z,
    input  logic       alu_c,
    input  logic       upd_en,
    input  logic [3:0] upd_mask,
    input  logic       flag_en,
    input  logic [2:0] flag_op,
    input  logic       load_p,
    input  logic       rti,
    input  logic [7:0] db_in,
    input  logic       int_entry,
    input  logic       push_b,
    input  logic       instr_done,
    output logic [7:0] p_push,
    output logic       c_out,
    output logic       d_out,
    output logic       irq_mask
);

    logic n_q, v_q, d_q, i_q, z_q, c_q;
    logic n_d, v_d, d_d, i_d, z_d, c_d;
    logic irq_mask_q, irq_mask_d;

    flag_op_e op;
    assign op = flag_op_e'(flag_op);

    // Bits 5 and 4 of a pulled byte have no storage behind them
    logic unused_db_bits;
    assign unused_db_bits = ^db_in[5:4];

    // N, V, Z, C: load, then explicit op, then masked ALU update.
    // Each flag resolves independently so an op on C does not block
    // ALU updates of the other three.
    always_comb begin
        n_d = n_q;
        v_d = v_q;
        z_d = z_q;
        c_d = c_q;
        if (load_p) begin
            n_d = db_in[P_N];
            v_d = db_in[P_V];
            z_d = db_in[P_Z];
            c_d = db_in[P_C];
        end else begin
            if (upd_en && upd_mask[UPD_N]) begin
                n_d = alu_n;
            end

            if (flag_en && op == FOP_CLV) begin
                v_d = 1'b0;
            end else if (upd_en && upd_mask[UPD_V]) begin
                v_d = alu_v;
            end

            if (upd_en && upd_mask[UPD_Z]) begin
                z_d = alu_z;
            end

            if (flag_en && (op == FOP_CLC || op == FOP_SEC)) begin
                c_d = (op == FOP_SEC);
            end else if (upd_en && upd_mask[UPD_C]) begin
                c_d = alu_c;
            end
        end
    end

    // D and I: load, then interrupt entry (I only), then explicit op
    always_comb begin
        d_d = d_q;
        i_d = i_q;
        if (load_p) begin
            d_d = db_in[P_D];
            i_d = db_in[P_I];
        end else begin
            if (int_entry) begin
                i_d = 1'b1;
            end else if (flag_en && (op == FOP_CLI || op == FOP_SEI)) begin
                i_d = (op == FOP_SEI);
            end

            if (flag_en && (op == FOP_CLD || op == FOP_SED)) begin
                d_d = (op == FOP_SED);
            end
        end
    end

    // The arbitration mask trails I by one instruction boundary, except for
    // RTI and interrupt entry which must take effect immediately.
    always_comb begin
        irq_mask_d = irq_mask_q;
        if (load_p && rti) begin
            irq_mask_d = db_in[P_I];
        end else if (int_entry) begin
            irq_mask_d = 1'b1;
        end else if (instr_done) begin
            irq_mask_d = i_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q <= P_RST[P_N];
            v_q <= P_RST[P_V];
            d_q <= P_RST[P_D];
            i_q <= P_RST[P_I];
            z_q <= P_RST[P_Z];
            c_q <= P_RST[P_C];
        end else begin
            n_q <= n_d;
            v_q <= v_d;
            d_q <= d_d;
            i_q <= i_d;
            z_q <= z_d;
            c_q <= c_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_mask_q <= P_RST[P_I];
        end else begin
            irq_mask_q <= irq_mask_d;
        end
    end

    assign p_push   = {n_q, v_q, 1'b1, push_b, d_q, i_q, z_q, c_q};
    assign c_out    = c_q;
    assign d_out    = d_q;
    assign irq_mask = irq_mask_q;

endmodule
